mdu_ctrl: RTL
=============

// Module: mdu_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer for the 32-bit MIPS core; owns the HI/LO registers.
//  Executes MULT/MULTU/DIV/DIVU iteratively (shift-add / restoring divide) and handles MTHI/MTLO.
//  Sits beside the ALU in EX. The pipeline stalls on Busy; MFHI/MFLO read the HI/LO ports directly.
// PARAMETERS
//  WIDTH   32   operand width; only 32 is verified
//  CNT_W   5    iteration counter width (clog2(WIDTH))
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      synchronous reset, active low
//  Start     in   1      request; sampled only in IDLE
//  MDUCode   in   3      000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others = nop
//  A         in   32     rs operand (dividend / multiplicand / MT data)
//  B         in   32     rt operand (divisor / multiplier)
//  Flush     in   1      abort any in-flight op; HI/LO keep their prior values
//  Busy      out  1      state != IDLE; the pipeline stalls while this is high
//  Done      out  1      1-cycle pulse; HI/LO hold the new result in the same cycle
//  HI        out  32     HI register (remainder / product upper word)
//  LO        out  32     LO register (quotient / product lower word)
// BEHAVIOUR
//  Reset: clk with rst_n=0 (any state, including mid-op) -> IDLE, HI=LO=0, Busy=0, Done=0, count=0.
//  States: IDLE, CALC, SIGN.
//   IDLE, Start=1, mult*/div* with B!=0 (or any mult):
//    - Latch |A| and |B| (signed ops only; unsigned ops pass operands through). |0x80000000| = 0x80000000.
//    - Latch neg_q = A[31]^B[31] and neg_r = A[31] (signed ops only).
//    - count=0, go to CALC.
//   IDLE, Start=1, div/divu with B==0: force rem=A, quo=32'hFFFF_FFFF, no negation; go to SIGN (Busy 1 cycle).
//   IDLE, Start=1, mthi/mtlo: write HI or LO = A at that edge. State stays IDLE; no Busy, no Done.
//   IDLE, Start=1, nop code: ignored.
//   CALC: one iteration per clk, 32 clks; at count==31 go to SIGN.
//    - mult: 64-bit {acc,mplr}. If mplr[0], acc = acc + mcand with 33-bit carry.
//      Then shift {carry,acc,mplr} right by 1.
//    - div: {rem,quo} shifted left 1. trial = rem - divisor in 33 bits.
//      If no borrow: rem = trial, quo[0] = 1; else quo[0] = 0.
//   SIGN: one clk.
//    - mult: {HI,LO} = neg ? -prod64 : prod64.
//    - div: LO = neg_q ? -quo : quo; HI = neg_r ? -rem : rem.
//    - Go to IDLE; Done=1 in the following cycle.
//  Latency: Start edge -> Busy high for 33 cycles (32 CALC + 1 SIGN) -> Done with valid HI/LO in cycle 34.
//  Start while Busy: ignored, not queued. Requesters hold Start until Busy has been seen low.
//  Flush=1 at any edge (non-reset) -> IDLE, Done=0, HI/LO unchanged.
//  Flush beats a simultaneous Start. A SIGN-state edge with Flush does not write HI/LO.
//  Arithmetic: all negations are two's complement modulo 2^32 or 2^64.
//   - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
//  Outputs are registered; no combinational path from inputs to Busy, Done, HI or LO.
// STRUCTURE
//  Shared header mdu_defs.vh holds:
//   - MDUCode encodings (MDU_MULT..MDU_MTLO);
//   - state encodings S_IDLE=2'd0, S_CALC=2'd1, S_SIGN=2'd2;
//   - MDU_ITER=32.
//  One sub-module, mdu_addsub33: 33-bit add/subtract returning {carry/borrow, sum}.
//  It is shared by the mult accumulate and the div trial subtract.
//  Negation is a separate 64-bit incrementer in the SIGN logic, not in the sub-module.
// TESTING
//  1 multu A=0xFFFFFFFF B=0xFFFFFFFF -> Busy high exactly 33 cycles; Done at cycle 34; HI=0xFFFFFFFE LO=0x00000001
//  2 mult A=0xFFFFFFFD(-3) B=5 -> HI=0xFFFFFFFF LO=0xFFFFFFF1; then multu same operands -> HI=0x00000004 LO=0xFFFFFFF1
//  3 div A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3 HI=1
//  4 div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0; divu A=0x55 B=0 -> Busy 1 cycle, HI=0x55 LO=0xFFFFFFFF
//  5 mult in flight: Start(divu) at cycle 5 ignored; Flush at cycle 10 -> Busy low next cycle, HI/LO = prior, no Done
//  6 mthi A=0x1234 in IDLE -> HI=0x1234 next cycle, Busy=0; rst_n=0 mid-CALC -> HI=LO=0, Busy=0, Done=0

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared constants, opcode encodings, FSM state type and helpers for the MDU sequencer.
package mdu_ctrl_pkg;

    localparam int unsigned MduWidth = 32;
    localparam int unsigned MduCntW  = 5;
    localparam int unsigned MduIter  = 32;

    localparam logic [2:0] MduMult  = 3'b000;
    localparam logic [2:0] MduMultu = 3'b001;
    localparam logic [2:0] MduDiv   = 3'b010;
    localparam logic [2:0] MduDivu  = 3'b011;
    localparam logic [2:0] MduMthi  = 3'b100;
    localparam logic [2:0] MduMtlo  = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StSign = 2'd2
    } mdu_state_e;

    // Magnitude of a two's-complement word; the most negative value maps to itself.
    function automatic logic [MduWidth-1:0] abs_word(input logic [MduWidth-1:0] x);
        return x[MduWidth-1] ? (~x + MduWidth'(1)) : x;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic                start;
    logic [2:0]          mdu_code;
    logic [MduWidth-1:0] a;
    logic [MduWidth-1:0] b;
    logic                flush;
    logic                busy;
    logic                done;
    logic [MduWidth-1:0] hi;
    logic [MduWidth-1:0] lo;

    modport master (
        output start, mdu_code, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mdu_code, a, b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_ctrl_addsub33.sv
// Shared add/subtract used by the multiply accumulate and the divide trial subtract.
// res[Width] is carry-out on add and borrow on subtract.
module mdu_ctrl_addsub33 #(
    parameter int unsigned Width = 33
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             sub,
    output logic [Width:0]   res
);

    // Zero-extend so the top bit carries the carry/borrow.
    always_comb begin
        res = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// acc holds the product upper word / remainder, shr the multiplier / quotient,
// opnd the multiplicand / divisor.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned Width = MduWidth,
    parameter int unsigned CntW  = MduCntW
) (
    input logic         clk,
    input logic         rst_n,
    mdu_ctrl_if.slave   bus
);

    mdu_state_e       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             is_div_q, is_div_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [Width-1:0] acc_q, acc_d;
    logic [Width-1:0] shr_q, shr_d;
    logic [Width-1:0] opnd_q, opnd_d;
    logic [Width-1:0] hi_q, hi_d;
    logic [Width-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic               is_signed;
    logic [Width:0]     add_a, add_b;
    logic               add_sub;
    logic [Width+1:0]   add_res;
    logic [2*Width-1:0] prod, prod_neg;

    assign is_signed = (bus.mdu_code == MduMult) || (bus.mdu_code == MduDiv);
    assign prod      = {acc_q, shr_q};
    assign prod_neg  = ~prod + (2*Width)'(1);

    // Adder operands: div trial uses the shifted remainder, mult adds mcand when mplr[0].
    always_comb begin
        if (is_div_q) begin
            add_a   = {acc_q, shr_q[Width-1]};
            add_b   = {1'b0, opnd_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, acc_q};
            add_b   = shr_q[0] ? {1'b0, opnd_q} : '0;
            add_sub = 1'b0;
        end
    end

    mdu_ctrl_addsub33 #(
        .Width (Width + 1)
    ) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .res (add_res)
    );

    // Next-state, datapath update and HI/LO write logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        shr_d     = shr_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.mdu_code)
                        MduMult, MduMultu: begin
                            is_div_d  = 1'b0;
                            acc_d     = '0;
                            opnd_d    = is_signed ? abs_word(bus.a) : bus.a;
                            shr_d     = is_signed ? abs_word(bus.b) : bus.b;
                            neg_quo_d = is_signed & (bus.a[Width-1] ^ bus.b[Width-1]);
                            neg_rem_d = 1'b0;
                            count_d   = '0;
                            state_d   = StCalc;
                        end
                        MduDiv, MduDivu: begin
                            is_div_d = 1'b1;
                            if (bus.b == '0) begin
                                // Divide by zero: skip iteration, result is rem=A, quo=all ones.
                                acc_d     = bus.a;
                                shr_d     = '1;
                                neg_quo_d = 1'b0;
                                neg_rem_d = 1'b0;
                                state_d   = StSign;
                            end else begin
                                acc_d     = '0;
                                shr_d     = is_signed ? abs_word(bus.a) : bus.a;
                                opnd_d    = is_signed ? abs_word(bus.b) : bus.b;
                                neg_quo_d = is_signed & (bus.a[Width-1] ^ bus.b[Width-1]);
                                neg_rem_d = is_signed & bus.a[Width-1];
                                count_d   = '0;
                                state_d   = StCalc;
                            end
                        end
                        MduMthi: hi_d = bus.a;
                        MduMtlo: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    if (!add_res[Width+1]) begin
                        acc_d = add_res[Width-1:0];
                        shr_d = {shr_q[Width-2:0], 1'b1};
                    end else begin
                        acc_d = add_a[Width-1:0];
                        shr_d = {shr_q[Width-2:0], 1'b0};
                    end
                end else begin
                    acc_d = add_res[Width:1];
                    shr_d = {add_res[0], shr_q[Width-1:1]};
                end
                count_d = count_q + CntW'(1);
                if (count_q == CntW'(MduIter - 1)) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                if (is_div_q) begin
                    lo_d = neg_quo_q ? (~shr_q + Width'(1)) : shr_q;
                    hi_d = neg_rem_q ? (~acc_q + Width'(1)) : acc_q;
                end else begin
                    {hi_d, lo_d} = neg_quo_q ? prod_neg : prod;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over everything, including a pending Start or SIGN write-back.
        if (bus.flush) begin
            state_d = StIdle;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            shr_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            shr_q     <= shr_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
